// File: rtl/jtag_dmi_pkg.sv
// jtag_dmi_pkg
// Shared definitions for the JTAG debug-module-interface data register:
// the update opcodes, the capture status codes, the request FSM states,
// the DR field layout and a helper that derives the capture status.
package jtag_dmi_pkg;

    // DR field layout, LSB-first: op/status, address, data.
    localparam int OP_W     = 2;
    localparam int OP_LSB   = 0;
    localparam int ADDR_LSB = OP_LSB + OP_W;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_CLEAR = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        STATUS_OK   = 2'd0,
        STATUS_FAIL = 2'd2,
        STATUS_BUSY = 2'd3
    } dmi_status_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_RSP = 2'd2
    } dmi_state_e;

    // Busy dominates fail so a debugger always learns it was too fast first.
    function automatic dmi_status_e dmi_status(input logic busy, input logic fail);
        dmi_status_e st;
        if (busy) begin
            st = STATUS_BUSY;
        end else if (fail) begin
            st = STATUS_FAIL;
        end else begin
            st = STATUS_OK;
        end
        return st;
    endfunction

endpackage

// File: rtl/jtag_dmi_dreg_shift_reg.sv
// jtag_shift_reg
// Generic W-bit JTAG data register: synchronous clear, parallel capture
// load, and LSB-out serial shift with new data entering at the MSB.
// Ports:
//   clk_i, rst_n_i  clock / async active-low reset
//   clr_i           synchronous clear (highest priority)
//   load_i          parallel load of load_data_i
//   shift_i         shift right, tdi_i into bit W-1
//   q_o             register contents (q_o[0] is the serial output)
module jtag_shift_reg #(
    parameter int W = 42
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic         tdi_i,
    input  logic [W-1:0] load_data_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    // Next value: clear beats capture beats shift.
    always_comb begin
        sr_d = sr_q;
        if (clr_i) begin
            sr_d = {W{1'b0}};
        end else if (load_i) begin
            sr_d = load_data_i;
        end else if (shift_i) begin
            sr_d = {tdi_i, sr_q[W-1:1]};
        end else begin
            sr_d = sr_q;
        end
    end

    // Register state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sr_q <= {W{1'b0}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q;

endmodule

// File: rtl/jtag_dmi_dreg.sv
// jtag_dmi_dreg
// Debug-module-interface DR for the JTAG TAP. A DR scan carries
// {data, addr, op}; Update-DR turns READ/WRITE into one valid/ready request
// to the debug module, and the response is captured on the next scan as
// {last_data, last_addr, status}. Sticky busy/fail flags refuse new work
// until a CLEAR op. All state lives in the tck domain.
// Ports:
//   tck, trstn                     test clock / async active-low reset
//   tdi, debug_tdo                 serial in / out (out = sr[0])
//   state_*                        TAP controller state strobes
//   insn_debug_select              this DR is selected by the IR
//   req_valid/ready, req_op/addr/wdata   request to the debug module
//   rsp_valid/ready, rsp_data/error      response from the debug module
module jtag_dmi_dreg
    import jtag_dmi_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 2
) (
    input  logic                  tck,
    input  logic                  trstn,
    input  logic                  tdi,
    input  logic                  state_test_logic_reset,
    input  logic                  state_capture_dr,
    input  logic                  state_shift_dr,
    input  logic                  state_update_dr,
    input  logic                  insn_debug_select,
    output logic                  debug_tdo,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_op,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  rsp_valid,
    output logic                  rsp_ready,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  rsp_error
);

    localparam int W        = OP_WIDTH + ADDR_WIDTH + DATA_WIDTH;
    localparam int DATA_LSB = OP_WIDTH + ADDR_WIDTH;

    logic [W-1:0]          sr_s;
    logic [W-1:0]          cap_data_s;
    dmi_status_e           status_s;
    dmi_op_e               upd_op_s;
    logic [ADDR_WIDTH-1:0] upd_addr_s;
    logic [DATA_WIDTH-1:0] upd_data_s;
    logic                  tlr_s;
    logic                  upd_s;
    logic                  clear_s;
    logic                  start_s;
    logic                  busy_hit_s;
    logic                  rsp_fire_s;

    dmi_state_e            state_q;
    logic                  req_valid_q;
    logic                  rsp_ready_q;
    logic                  req_op_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;

    logic                  busy_q;
    logic                  busy_d;
    logic                  fail_q;
    logic                  fail_d;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic [ADDR_WIDTH-1:0] last_addr_d;
    logic [DATA_WIDTH-1:0] last_data_q;
    logic [DATA_WIDTH-1:0] last_data_d;

    assign tlr_s = state_test_logic_reset;

    // The FSM being away from IDLE reads as busy even before the sticky flag is set.
    assign status_s   = dmi_status(busy_q || (state_q != S_IDLE), fail_q);
    assign cap_data_s = {last_data_q, last_addr_q, status_s};

    jtag_shift_reg #(
        .W (W)
    ) u_sr (
        .clk_i       (tck),
        .rst_n_i     (trstn),
        .clr_i       (tlr_s),
        .load_i      (state_capture_dr && insn_debug_select),
        .shift_i     (state_shift_dr && insn_debug_select),
        .tdi_i       (tdi),
        .load_data_i (cap_data_s),
        .q_o         (sr_s)
    );

    assign upd_op_s   = dmi_op_e'(sr_s[OP_WIDTH-1:0]);
    assign upd_addr_s = sr_s[DATA_LSB-1:OP_WIDTH];
    assign upd_data_s = sr_s[W-1:DATA_LSB];

    assign upd_s      = state_update_dr && insn_debug_select && !tlr_s;
    assign clear_s    = upd_s && (upd_op_s == OP_CLEAR);
    assign busy_hit_s = upd_s && (upd_op_s != OP_CLEAR) && (state_q != S_IDLE);
    assign start_s    = upd_s && ((upd_op_s == OP_READ) || (upd_op_s == OP_WRITE)) &&
                        (state_q == S_IDLE) && !busy_q && !fail_q;
    assign rsp_fire_s = (state_q == S_WAIT_RSP) && rsp_valid;

    // Sticky flags and the last-transaction record. A response accepted in the
    // same cycle as CLEAR still reports its failure.
    always_comb begin
        busy_d      = busy_q;
        fail_d      = fail_q;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        if (tlr_s) begin
            busy_d      = 1'b0;
            fail_d      = 1'b0;
            last_addr_d = {ADDR_WIDTH{1'b0}};
            last_data_d = {DATA_WIDTH{1'b0}};
        end else begin
            if (clear_s) begin
                busy_d = 1'b0;
            end else if (busy_hit_s) begin
                busy_d = 1'b1;
            end else begin
                busy_d = busy_q;
            end
            if (rsp_fire_s && rsp_error) begin
                fail_d = 1'b1;
            end else if (clear_s) begin
                fail_d = 1'b0;
            end else begin
                fail_d = fail_q;
            end
            if (start_s) begin
                last_addr_d = upd_addr_s;
            end else begin
                last_addr_d = last_addr_q;
            end
            // Writes leave the previous read data visible.
            if (rsp_fire_s && !req_op_q) begin
                last_data_d = rsp_data;
            end else begin
                last_data_d = last_data_q;
            end
        end
    end

    // Register sticky flags and the last-transaction record.
    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            busy_q      <= 1'b0;
            fail_q      <= 1'b0;
            last_addr_q <= {ADDR_WIDTH{1'b0}};
            last_data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            busy_q      <= busy_d;
            fail_q      <= fail_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
        end
    end

    // Request FSM with registered handshake outputs. Test-Logic-Reset does not
    // touch it so an outstanding handshake always finishes cleanly.
    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            state_q     <= S_IDLE;
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
            req_op_q    <= 1'b0;
            req_addr_q  <= {ADDR_WIDTH{1'b0}};
            req_wdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_s) begin
                        state_q     <= S_REQ;
                        req_valid_q <= 1'b1;
                        req_op_q    <= (upd_op_s == OP_WRITE);
                        req_addr_q  <= upd_addr_s;
                        req_wdata_q <= upd_data_s;
                    end
                end
                S_REQ: begin
                    if (req_ready) begin
                        state_q     <= S_WAIT_RSP;
                        req_valid_q <= 1'b0;
                        rsp_ready_q <= 1'b1;
                    end
                end
                S_WAIT_RSP: begin
                    if (rsp_valid) begin
                        state_q     <= S_IDLE;
                        rsp_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_valid_q <= 1'b0;
                    rsp_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign debug_tdo = sr_s[0];
    assign req_valid = req_valid_q;
    assign rsp_ready = rsp_ready_q;
    assign req_op    = req_op_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;

endmodule

// File: tb/tb_jtag_dmi_dreg.sv
// tb_jtag_dmi_dreg
// Self-checking bench for jtag_dmi_dreg: directed scenarios plus randomized
// scans, every cycle compared against a transaction-level reference model.
module tb_jtag_dmi_dreg;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int W  = 42;

    logic          tck = 1'b0;
    logic          trstn = 1'b0;
    logic          tdi = 1'b0;
    logic          tlr = 1'b0;
    logic          cap = 1'b0;
    logic          shf = 1'b0;
    logic          upd = 1'b0;
    logic          sel = 1'b0;
    logic          debug_tdo;
    logic          req_valid;
    logic          req_ready = 1'b0;
    logic          req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid = 1'b0;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data = '0;
    logic          rsp_error = 1'b0;

    int checks = 0;
    int failures = 0;

    // Stimulus knobs for the debug-module side.
    int            rdy_pct = 0;
    int            rspv_pct = 0;
    int            err_pct = 0;
    bit            rand_data = 1'b0;
    logic [DW-1:0] fixed_rsp = '0;

    // Reference model: DR contents, sticky flags, last record, one outstanding transaction.
    logic [W-1:0]  m_sr;
    bit            m_busy, m_fail, m_pend, m_acc, m_op;
    logic [AW-1:0] m_last_addr, m_addr;
    logic [DW-1:0] m_last_data, m_wdata;

    logic [W-1:0]  out;

    jtag_dmi_dreg dut (
        .tck                    (tck),
        .trstn                  (trstn),
        .tdi                    (tdi),
        .state_test_logic_reset (tlr),
        .state_capture_dr       (cap),
        .state_shift_dr         (shf),
        .state_update_dr        (upd),
        .insn_debug_select      (sel),
        .debug_tdo              (debug_tdo),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .req_op                 (req_op),
        .req_addr               (req_addr),
        .req_wdata              (req_wdata),
        .rsp_valid              (rsp_valid),
        .rsp_ready              (rsp_ready),
        .rsp_data               (rsp_data),
        .rsp_error              (rsp_error)
    );

    always #5 tck = ~tck;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_sr = '0; m_busy = 1'b0; m_fail = 1'b0; m_pend = 1'b0; m_acc = 1'b0; m_op = 1'b0;
        m_last_addr = '0; m_addr = '0; m_last_data = '0; m_wdata = '0;
    endfunction

    // One tck edge of the reference model, from the inputs present at the edge.
    function automatic void model_step();
        logic [1:0]    op;
        logic [1:0]    status;
        logic [W-1:0]  sr_n;
        bit            upd_e;
        bit            busy_n, fail_n, pend_n, acc_n, op_n;
        logic [AW-1:0] la_n, addr_n;
        logic [DW-1:0] ld_n, wd_n;
        op     = m_sr[1:0];
        status = (m_busy || m_pend) ? 2'd3 : (m_fail ? 2'd2 : 2'd0);
        upd_e  = upd && sel && !tlr;
        sr_n   = m_sr;
        if (tlr) sr_n = '0;
        else if (cap && sel) sr_n = {m_last_data, m_last_addr, status};
        else if (shf && sel) sr_n = {tdi, m_sr[W-1:1]};
        busy_n = m_busy; fail_n = m_fail; pend_n = m_pend; acc_n = m_acc; op_n = m_op;
        la_n = m_last_addr; addr_n = m_addr; ld_n = m_last_data; wd_n = m_wdata;
        if (upd_e) begin
            if (op == 2'd3) begin
                busy_n = 1'b0; fail_n = 1'b0;
            end else if (m_pend) begin
                busy_n = 1'b1;
            end else if (op != 2'd0 && !m_busy && !m_fail) begin
                pend_n = 1'b1; acc_n = 1'b0; op_n = (op == 2'd2);
                addr_n = m_sr[9:2]; wd_n = m_sr[41:10]; la_n = m_sr[9:2];
            end
        end
        if (m_pend && !m_acc && req_ready) acc_n = 1'b1;
        if (m_pend && m_acc && rsp_valid) begin
            pend_n = 1'b0; acc_n = 1'b0;
            if (!m_op) ld_n = rsp_data;
            if (rsp_error) fail_n = 1'b1;
        end
        if (tlr) begin
            busy_n = 1'b0; fail_n = 1'b0; la_n = '0; ld_n = '0;
        end
        m_sr = sr_n; m_busy = busy_n; m_fail = fail_n; m_pend = pend_n; m_acc = acc_n;
        m_op = op_n; m_last_addr = la_n; m_addr = addr_n; m_last_data = ld_n; m_wdata = wd_n;
    endfunction

    task automatic check_outputs();
        check_eq("tdo", 64'(debug_tdo), 64'(m_sr[0]));
        check_eq("req_valid", 64'(req_valid), 64'(m_pend && !m_acc));
        check_eq("rsp_ready", 64'(rsp_ready), 64'(m_pend && m_acc));
        check_eq("req_op", 64'(req_op), 64'(m_op));
        check_eq("req_addr", 64'(req_addr), 64'(m_addr));
        check_eq("req_wdata", 64'(req_wdata), 64'(m_wdata));
    endtask

    task automatic tick(input bit c, input bit s, input bit u, input bit t, input bit sl, input bit ti);
        cap = c; shf = s; upd = u; tlr = t; sel = sl; tdi = ti;
        req_ready = (int'($urandom_range(0, 99)) < rdy_pct);
        rsp_valid = (int'($urandom_range(0, 99)) < rspv_pct);
        rsp_error = (int'($urandom_range(0, 99)) < err_pct);
        rsp_data  = rand_data ? DW'($urandom) : fixed_rsp;
        @(posedge tck);
        if (!trstn) model_reset();
        else model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Full DR scan: capture, W shifts (recording what comes out), update.
    task automatic scan(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit sl, output logic [W-1:0] so);
        logic [W-1:0] word;
        word = {d, a, op};
        tick(1'b1, 1'b0, 1'b0, 1'b0, sl, 1'b0);
        for (int i = 0; i < W; i++) begin
            so[i] = debug_tdo;
            tick(1'b0, 1'b1, 1'b0, 1'b0, sl, word[i]);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0, sl, 1'b0);
    endtask

    task automatic pulse_trstn();
        trstn = 1'b0;
        #1;
        model_reset();
        check_eq("trst_req_valid", 64'(req_valid), 64'd0);
        check_eq("trst_rsp_ready", 64'(rsp_ready), 64'd0);
        check_eq("trst_req_addr", 64'(req_addr), 64'd0);
        check_eq("trst_tdo", 64'(debug_tdo), 64'd0);
        idle(2);
        trstn = 1'b1;
    endtask

    initial begin
        logic [1:0] rop;
        model_reset();
        idle(2);
        check_eq("rst_req_valid", 64'(req_valid), 64'd0);
        check_eq("rst_req_op", 64'(req_op), 64'd0);
        check_eq("rst_req_wdata", 64'(req_wdata), 64'd0);
        check_eq("rst_rsp_ready", 64'(rsp_ready), 64'd0);
        check_eq("rst_tdo", 64'(debug_tdo), 64'd0);
        trstn = 1'b1;
        idle(1);

        // trstn in the middle of a request.
        rdy_pct = 0; rspv_pct = 0; err_pct = 0;
        scan(2'd2, 8'h33, 32'h0000_0001, 1'b1, out);
        idle(1);
        check_eq("midreq_valid", 64'(req_valid), 64'd1);
        pulse_trstn();
        scan(2'd0, 8'h00, 32'h0, 1'b1, out);
        check_eq("trst_status", 64'(out[1:0]), 64'd0);

        // WRITE held off by req_ready for three cycles.
        scan(2'd2, 8'h10, 32'hDEADBEEF, 1'b1, out);
        check_eq("wr_valid", 64'(req_valid), 64'd1);
        check_eq("wr_addr", 64'(req_addr), 64'h10);
        check_eq("wr_data", 64'(req_wdata), 64'hDEADBEEF);
        check_eq("wr_op", 64'(req_op), 64'd1);
        idle(3);
        check_eq("wr_valid_held", 64'(req_valid), 64'd1);
        rdy_pct = 100;
        idle(1);
        check_eq("wr_accepted", 64'(rsp_ready), 64'd1);
        rdy_pct = 0; rspv_pct = 100;
        idle(1);
        rspv_pct = 0;
        check_eq("wr_done", 64'(rsp_ready), 64'd0);
        scan(2'd0, 8'h00, 32'h0, 1'b1, out);
        check_eq("wr_status", 64'(out[1:0]), 64'd0);

        // READ and scan the result out.
        fixed_rsp = 32'h12345678; rdy_pct = 100;
        scan(2'd1, 8'h04, 32'h0, 1'b1, out);
        idle(1);
        rspv_pct = 100;
        idle(1);
        rspv_pct = 0;
        scan(2'd0, 8'h00, 32'h0, 1'b1, out);
        check_eq("rd_scan_out", 64'(out), 64'({32'h12345678, 8'h04, 2'b00}));

        // Update while waiting for the response -> sticky busy.
        scan(2'd1, 8'h01, 32'h0, 1'b1, out);
        idle(1);
        scan(2'd0, 8'h00, 32'h0, 1'b1, out);
        check_eq("wait_status", 64'(out[1:0]), 64'd3);
        rspv_pct = 100;
        idle(1);
        rspv_pct = 0;
        scan(2'd0, 8'h00, 32'h0, 1'b1, out);
        check_eq("sticky_busy", 64'(out[1:0]), 64'd3);
        scan(2'd3, 8'h00, 32'h0, 1'b1, out);
        scan(2'd0, 8'h00, 32'h0, 1'b1, out);
        check_eq("clear_status", 64'(out[1:0]), 64'd0);

        // Error response -> sticky fail blocks requests until CLEAR.
        scan(2'd1, 8'h02, 32'h0, 1'b1, out);
        idle(1);
        err_pct = 100; rspv_pct = 100;
        idle(1);
        err_pct = 0; rspv_pct = 0;
        scan(2'd0, 8'h00, 32'h0, 1'b1, out);
        check_eq("fail_status", 64'(out[1:0]), 64'd2);
        scan(2'd1, 8'h03, 32'h0, 1'b1, out);
        check_eq("fail_ignored", 64'(req_valid), 64'd0);
        idle(2);
        scan(2'd3, 8'h00, 32'h0, 1'b1, out);
        rdy_pct = 0;
        scan(2'd1, 8'h03, 32'h0, 1'b1, out);
        check_eq("after_clear", 64'(req_valid), 64'd1);
        rdy_pct = 100;
        idle(1);
        rspv_pct = 100;
        idle(1);
        rspv_pct = 0;

        // Test-Logic-Reset while waiting for a response.
        fixed_rsp = 32'hCAFEF00D;
        scan(2'd1, 8'h05, 32'h0, 1'b1, out);
        idle(1);
        scan(2'd0, 8'h00, 32'h0, 1'b1, out);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("tlr_rsp_ready", 64'(rsp_ready), 64'd1);
        rspv_pct = 100;
        idle(1);
        rspv_pct = 0;
        check_eq("tlr_done", 64'(rsp_ready), 64'd0);
        scan(2'd0, 8'h00, 32'h0, 1'b1, out);
        check_eq("tlr_scan_out", 64'(out), 64'({32'hCAFEF00D, 8'h00, 2'b00}));

        // Randomized scans against the model.
        rand_data = 1'b1;
        for (int it = 0; it < 40; it++) begin
            rdy_pct  = int'($urandom_range(20, 100));
            rspv_pct = int'($urandom_range(10, 60));
            err_pct  = int'($urandom_range(0, 30));
            rop = 2'($urandom_range(0, 3));
            scan(rop, AW'($urandom), DW'($urandom), ($urandom_range(0, 5) != 0), out);
            idle(int'($urandom_range(0, 4)));
            if ($urandom_range(0, 9) == 0) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        rdy_pct = 100; rspv_pct = 100; err_pct = 0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
